// File: rtl/pmod_dac.sv
// Registered driver for an 8-bit R-2R ladder DAC on a PMOD header.
// Samples arrive over valid/ready; after each update new samples are held off for SETTLE_CYCLES clocks.
module pmod_dac #(
  parameter int          SETTLE_CYCLES = 0,
  parameter logic [7:0]  RESET_CODE    = 8'h00
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_PMOD_1,
  output logic       o_PMOD_2,
  output logic       o_PMOD_3,
  output logic       o_PMOD_4,
  output logic       o_PMOD_5,
  output logic       o_PMOD_6,
  output logic       o_PMOD_7,
  output logic       o_PMOD_8,
  output logic [7:0] o_code
);

  localparam logic [15:0] SETTLE_W = 16'(SETTLE_CYCLES);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [7:0]  code_r;
  logic [7:0]  code_nxt_s;
  logic        ready_r;
  logic        ready_nxt_s;
  logic        accept_s;

  assign accept_s = i_valid && ready_r;

  // State, counter, code and ready registers; reset wins over a simultaneous acceptance
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      code_r  <= RESET_CODE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      code_r  <= code_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  // Next-state, settle countdown and code capture
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    code_nxt_s  = code_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          code_nxt_s = i_byte;
          if (SETTLE_W != 16'd0) begin
            state_nxt_s = SETTLE;
            cnt_nxt_s   = SETTLE_W;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 16'd0;
          end
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 16'd0;
        end
      end
      SETTLE: begin
        // Leaving on the edge where the count reaches zero re-opens ready on that same edge
        if (cnt_r > 16'd1) begin
          state_nxt_s = SETTLE;
          cnt_nxt_s   = cnt_r - 16'd1;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 16'd0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 16'd0;
      end
    endcase
  end

  // Ready is decoded from the next state so the pin itself comes straight from a flop
  always_comb begin
    case (state_nxt_s)
      IDLE:    ready_nxt_s = 1'b1;
      SETTLE:  ready_nxt_s = 1'b0;
      default: ready_nxt_s = 1'b1;
    endcase
  end

  assign o_ready  = ready_r;
  assign o_code   = code_r;
  assign o_PMOD_1 = code_r[7];
  assign o_PMOD_2 = code_r[6];
  assign o_PMOD_3 = code_r[5];
  assign o_PMOD_4 = code_r[4];
  assign o_PMOD_5 = code_r[3];
  assign o_PMOD_6 = code_r[2];
  assign o_PMOD_7 = code_r[1];
  assign o_PMOD_8 = code_r[0];

endmodule

// File: tb/tb_pmod_dac.sv
// Directed bench for pmod_dac: one instance with no settle time, one with a 3-cycle settle and RESET_CODE 8'h80.
module tb_pmod_dac;

  logic       clk = 1'b0;
  int         errors = 0;
  int         checks = 0;

  logic       rst0, valid0, ready0;
  logic [7:0] byte0, code0;
  logic       p0_1, p0_2, p0_3, p0_4, p0_5, p0_6, p0_7, p0_8;
  logic       rst3, valid3, ready3;
  logic [7:0] byte3, code3;
  logic       p3_1, p3_2, p3_3, p3_4, p3_5, p3_6, p3_7, p3_8;
  logic [7:0] pins0, pins3;
  logic [7:0] vec [4];

  assign pins0 = {p0_1, p0_2, p0_3, p0_4, p0_5, p0_6, p0_7, p0_8};
  assign pins3 = {p3_1, p3_2, p3_3, p3_4, p3_5, p3_6, p3_7, p3_8};

  always #5 clk = ~clk;

  pmod_dac #(.SETTLE_CYCLES(0), .RESET_CODE(8'h00)) dut0 (
    .i_Clk(clk), .i_Rst_L(rst0), .i_byte(byte0), .i_valid(valid0), .o_ready(ready0),
    .o_PMOD_1(p0_1), .o_PMOD_2(p0_2), .o_PMOD_3(p0_3), .o_PMOD_4(p0_4),
    .o_PMOD_5(p0_5), .o_PMOD_6(p0_6), .o_PMOD_7(p0_7), .o_PMOD_8(p0_8),
    .o_code(code0)
  );

  pmod_dac #(.SETTLE_CYCLES(3), .RESET_CODE(8'h80)) dut3 (
    .i_Clk(clk), .i_Rst_L(rst3), .i_byte(byte3), .i_valid(valid3), .o_ready(ready3),
    .o_PMOD_1(p3_1), .o_PMOD_2(p3_2), .o_PMOD_3(p3_3), .o_PMOD_4(p3_4),
    .o_PMOD_5(p3_5), .o_PMOD_6(p3_6), .o_PMOD_7(p3_7), .o_PMOD_8(p3_8),
    .o_code(code3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b0; valid0 = 1'b0; byte0 = 8'h00;
    rst3 = 1'b0; valid3 = 1'b0; byte3 = 8'h00;
    vec[0] = 8'hFF; vec[1] = 8'h00; vec[2] = 8'h80; vec[3] = 8'h01;

    // Reset state of both instances
    step();
    chk("rst0_code",  code0, 8'h00);
    chk("rst0_pins",  pins0, 8'h00);
    chk("rst0_ready", {7'd0, ready0}, 8'h01);
    chk("rst3_code",  code3, 8'h80);
    chk("rst3_pins",  pins3, 8'h80);
    chk("rst3_ready", {7'd0, ready3}, 8'h01);

    // Held reset with random traffic on the default-code instance
    for (int i = 0; i < 5; i++) begin
      byte0  = 8'($urandom);
      valid0 = 1'($urandom);
      step();
      chk("rsthold_pins",  pins0, 8'h00);
      chk("rsthold_ready", {7'd0, ready0}, 8'h01);
    end

    // Bit mapping: 8'h46 -> pins 0,1,0,0,0,1,1,0
    rst0 = 1'b1; byte0 = 8'h46; valid0 = 1'b1;
    step();
    chk("map_pins",  pins0, 8'b0100_0110);
    chk("map_code",  code0, 8'h46);
    chk("map_pmod1", {7'd0, p0_1}, 8'h00);
    chk("map_pmod2", {7'd0, p0_2}, 8'h01);
    chk("map_pmod8", {7'd0, p0_8}, 8'h00);

    // Back-to-back extremes with no settle time
    for (int i = 0; i < 4; i++) begin
      byte0 = vec[i];
      step();
      chk("b2b_code",  code0, vec[i]);
      chk("b2b_pins",  pins0, vec[i]);
      chk("b2b_ready", {7'd0, ready0}, 8'h01);
    end
    valid0 = 1'b0; byte0 = 8'h77;
    step();
    chk("hold_code", code0, 8'h01);

    // Settle hold-off: accept 8'h12 at N, 8'h34 held valid
    rst3 = 1'b1; byte3 = 8'h12; valid3 = 1'b1;
    step();
    chk("set_N_code",  code3, 8'h12);
    chk("set_N_ready", {7'd0, ready3}, 8'h00);
    byte3 = 8'h34;
    for (int i = 1; i <= 2; i++) begin
      step();
      chk("set_mid_code",  code3, 8'h12);
      chk("set_mid_ready", {7'd0, ready3}, 8'h00);
    end
    step();
    chk("set_N3_code",  code3, 8'h12);
    chk("set_N3_ready", {7'd0, ready3}, 8'h01);
    step();
    chk("set_N4_code",  code3, 8'h34);
    chk("set_N4_ready", {7'd0, ready3}, 8'h00);

    // Single-cycle valid pulse with 8'hAA during settle must be dropped
    byte3 = 8'hAA; valid3 = 1'b1;
    step();
    valid3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ign_code", code3, 8'h34);
      step();
    end
    chk("ign_code_end", code3, 8'h34);
    chk("ign_ready",    {7'd0, ready3}, 8'h01);

    // Reset mid-settle with a competing 8'h55 sample
    byte3 = 8'h3C; valid3 = 1'b1;
    step();
    chk("pre_rst_code",  code3, 8'h3C);
    chk("pre_rst_ready", {7'd0, ready3}, 8'h00);
    rst3 = 1'b0; byte3 = 8'h55;
    step();
    chk("midrst_code",  code3, 8'h80);
    chk("midrst_pins",  pins3, 8'h80);
    chk("midrst_ready", {7'd0, ready3}, 8'h01);
    rst3 = 1'b1; valid3 = 1'b0;
    step();
    chk("postrst_code",  code3, 8'h80);
    chk("postrst_ready", {7'd0, ready3}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
